// File: rtl/uart_tx_if.sv
// Handshake and serial-line bundle for the 8N1 UART transmitter.
//   tx_start : request to send tx_data (level-sampled while tx_ready is high)
//   tx_data  : byte to send, captured on the accepting edge
//   tx_ready : transmitter idle and able to accept a request
//   tx       : serial line, idles high
// master = requester side, slave = transmitter side.
interface uart_tx_if;
    localparam int unsigned DATA_W = 8;

    logic              tx_start;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              tx;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_ready,
        input  tx
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_ready,
        output tx
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit, each
// lasting CLKS_PER_BIT = CLK_FREQ / BAUD_RATE clock cycles.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (aborts any frame, line goes high)
//   bus : uart_tx_if.slave (tx_start, tx_data in; tx_ready, tx out)
// tx and tx_ready come straight from flip-flops; their next values are
// derived from the next state so they change on the same edge as the FSM.
module uart_tx #(
    parameter int unsigned CLK_FREQ  = 100000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    uart_tx_if.slave   bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned IDX_W        = 3;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;
    logic [DATA_W-1:0]   shreg_q;
    logic [DATA_W-1:0]   shreg_d;
    logic                tx_q;
    logic                tx_d;
    logic                ready_q;
    logic                ready_d;
    logic                bit_done;

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
        end
    end

    assign bit_done = (cnt_q == CNT_MAX);

    // Next-state and datapath update; the bit counter restarts at every bit boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                    shreg_d = bus.tx_data;
                end
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d = '0;
                    if (idx_q == IDX_MAX) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the coming state; idle never looks at tx_data.
    always_comb begin
        tx_d    = 1'b1;
        ready_d = 1'b0;
        case (state_d)
            IDLE:    ready_d = 1'b1;
            START:   tx_d    = 1'b0;
            DATA:    tx_d    = shreg_d[idx_d];
            STOP:    tx_d    = 1'b1;
            default: tx_d    = 1'b1;
        endcase
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = ready_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: one instance at the default 868 clocks
// per bit, one at CLK_FREQ=1000 / BAUD_RATE=100 (10 clocks per bit).
// Outputs are sampled on the falling clock edge.
module tb_uart_tx;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    uart_tx_if bus_a ();
    uart_tx_if bus_b ();

    uart_tx u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    uart_tx #(
        .CLK_FREQ  (1000),
        .BAUD_RATE (100)
    ) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        bit         sel;      // 0: default instance, 1: 10-clock instance
        logic [7:0] data;
        int         hold;     // cycles tx_start stays high after acceptance edge
        int         chg_at;   // sample index at which tx_data is overwritten (-1: never)
        logic [7:0] chg_val;
        logic [9:0] levels;   // expected line level per bit, [0] = start bit
        int         quiet;    // idle cycles checked after the frame
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic get_tx(input bit sel);
        return sel ? bus_b.tx : bus_a.tx;
    endfunction

    function automatic logic get_ready(input bit sel);
        return sel ? bus_b.tx_ready : bus_a.tx_ready;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) bus_b.tx_start = v;
        else     bus_a.tx_start = v;
    endtask

    task automatic set_data(input bit sel, input logic [7:0] v);
        if (sel) bus_b.tx_data = v;
        else     bus_a.tx_data = v;
    endtask

    // Called at a falling edge: raise the request, then check every cycle of the frame.
    task automatic send_frame(input bit sel, input logic [7:0] data, input int hold,
                              input int chg_at, input logic [7:0] chg_val,
                              input logic [9:0] levels, input string name);
        int cpb;
        int g;
        int bad_lvl;
        int bad_rdy;
        cpb = sel ? 10 : 868;
        g   = 0;
        set_start(sel, 1'b1);
        set_data(sel, data);
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            bad_lvl = 0;
            bad_rdy = 0;
            for (int c = 0; c < cpb; c++) begin
                if (get_tx(sel) !== levels[b]) bad_lvl++;
                if (get_ready(sel) !== 1'b0)   bad_rdy++;
                if (hold > 0 && g == hold - 1) set_start(sel, 1'b0);
                if (g == chg_at)               set_data(sel, chg_val);
                g++;
                @(negedge clk);
            end
            check($sformatf("%s bit%0d wrong-level cycles", name, b), 32'(bad_lvl), 32'd0);
            check($sformatf("%s bit%0d ready-high cycles", name, b), 32'(bad_rdy), 32'd0);
        end
        check($sformatf("%s ready after frame", name), 32'(get_ready(sel)), 32'd1);
        check($sformatf("%s tx after frame", name), 32'(get_tx(sel)), 32'd1);
    endtask

    task automatic check_idle(input bit sel, input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            if (get_tx(sel) !== 1'b1 || get_ready(sel) !== 1'b1) bad++;
            @(negedge clk);
        end
        check($sformatf("%s non-idle cycles", name), 32'(bad), 32'd0);
    endtask

    task automatic add_vec(input int i, input string name, input bit sel, input logic [7:0] data,
                           input int hold, input int chg_at, input logic [7:0] chg_val,
                           input logic [9:0] levels, input int quiet);
        vecs[i].name    = name;
        vecs[i].sel     = sel;
        vecs[i].data    = data;
        vecs[i].hold    = hold;
        vecs[i].chg_at  = chg_at;
        vecs[i].chg_val = chg_val;
        vecs[i].levels  = levels;
        vecs[i].quiet   = quiet;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;

        //             name             sel   data   hold chg  chg_val  {stop, data, start}  quiet
        add_vec(0, "single 0x6A",       1'b0, 8'h6A, 2,   -1,  8'h00,   10'b1_01101010_0,    20000);
        add_vec(1, "stable 0x00",       1'b0, 8'h00, 1,   0,   8'hFF,   10'b1_00000000_0,    5);
        add_vec(2, "small 0xFF",        1'b1, 8'hFF, 1,   -1,  8'h00,   10'b1_11111111_0,    5);
        add_vec(3, "small 0x81",        1'b1, 8'h81, 1,   3,   8'h7E,   10'b1_10000001_0,    5);
        add_vec(4, "small 0x5A",        1'b1, 8'h5A, 3,   -1,  8'h00,   10'b1_01011010_0,    5);

        // Reset: line idle throughout; a request held on the small instance
        // during reset must only be taken on the first edge after release.
        rst            = 1'b1;
        bus_a.tx_start = 1'b0;
        bus_a.tx_data  = 'x;
        bus_b.tx_start = 1'b1;
        bus_b.tx_data  = 8'h96;
        #1;
        check("reset tx a",    32'(bus_a.tx),       32'd1);
        check("reset ready a", 32'(bus_a.tx_ready), 32'd1);
        check("reset tx b",    32'(bus_b.tx),       32'd1);
        check("reset ready b", 32'(bus_b.tx_ready), 32'd1);
        @(negedge clk);
        check_idle(0, 2, "in reset a");
        check_idle(1, 0, "in reset b0");
        check("in reset tx b", 32'(bus_b.tx), 32'd1);
        rst = 1'b0;
        fork
            check_idle(0, 20, "after reset a");
            send_frame(1, 8'h96, 1, -1, 8'h00, 10'b1_10010110_0, "post-reset 0x96");
        join
        check_idle(1, 3, "post-reset b idle");

        // Table-driven frames.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].sel, vecs[i].data, vecs[i].hold, vecs[i].chg_at,
                       vecs[i].chg_val, vecs[i].levels, vecs[i].name);
            check_idle(vecs[i].sel, vecs[i].quiet, vecs[i].name);
        end

        // Back-to-back: request held high across both frames; second frame
        // is accepted on the first idle edge.
        send_frame(0, 8'h55, 0, -1, 8'h00, 10'b1_01010101_0, "b2b 0x55");
        send_frame(0, 8'hAA, 1, -1, 8'h00, 10'b1_10101010_0, "b2b 0xAA");
        check_idle(0, 5, "after b2b");

        // Mid-frame reset during data bit 3, then a clean frame.
        bus_a.tx_start = 1'b1;
        bus_a.tx_data  = 8'hC3;
        @(negedge clk);
        bus_a.tx_start = 1'b0;
        repeat (4 * 868 + 10) @(negedge clk);
        check("pre-reset bit3 tx", 32'(bus_a.tx),       32'd0);
        check("pre-reset ready",   32'(bus_a.tx_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("async reset tx",    32'(bus_a.tx),       32'd1);
        check("async reset ready", 32'(bus_a.tx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        check_idle(0, 5, "after mid reset");
        send_frame(0, 8'h3C, 1, -1, 8'h00, 10'b1_00111100_0, "after reset 0x3C");
        check_idle(0, 5, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
